// File: rtl/gate_truth_sweeper.sv
// Drives all four {A,B} vectors into a 2-input gate, captures its truth table and
// compares it with EXPECTED. Optional macro SWEEP_EARLY_ABORT_EN stops at the first mismatch.
module gate_truth_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b0110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       c_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic       pass,
    output logic [2:0] err_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             rearm;

    logic [3:0]       truth_cap;
    logic [IDX_W-1:0] idx_nxt;
    logic             mismatch;
    logic             finish;
    logic [2:0]       diff_cnt;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

    // Table as it will look after the current SAMPLE cycle
    always_comb begin
        truth_cap      = truth;
        truth_cap[idx] = c_in;
        idx_nxt        = IDX_W'(idx + 2'd1);
        mismatch       = (c_in != EXPECTED[idx]);
        diff_cnt       = popcount4(truth_cap ^ EXPECTED);
`ifdef SWEEP_EARLY_ABORT_EN
        finish         = (idx == 2'd3) || mismatch;
`else
        finish         = (idx == 2'd3);
`endif
    end

    // rearm blocks a start held through DONE for the first IDLE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            rearm     <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            truth     <= '0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    rearm <= 1'b0;
                    if (start && !rearm) begin
                        state     <= SETTLE;
                        idx       <= '0;
                        cnt       <= '0;
                        truth     <= '0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    cnt <= CNT_W'(cnt + 4'd1);
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    truth <= truth_cap;
                    if (finish) begin
                        state <= DONE;
                        done  <= 1'b1;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
`ifdef SWEEP_EARLY_ABORT_EN
                        pass      <= !mismatch && (truth_cap == EXPECTED);
                        err_count <= mismatch ? 3'd1 : diff_cnt;
`else
                        pass      <= (truth_cap == EXPECTED);
                        err_count <= diff_cnt;
`endif
                    end else begin
                        state <= SETTLE;
                        idx   <= idx_nxt;
                        cnt   <= '0;
                        a_out <= idx_nxt[1];
                        b_out <= idx_nxt[0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rearm <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: table-driven and random gate tables against a
// behavioural model, plus reset-abort and back-to-back start sequences.
module tb_gate_truth_sweeper;

    localparam int unsigned S    = 2;
    localparam logic [3:0]  EXP  = 4'b0110;
    localparam int unsigned S2   = 1;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic       c_in, c_in2;
    logic       a_out, b_out, busy, done, pass;
    logic       a_out2, b_out2, busy2, done2, pass2;
    logic [3:0] truth, truth2;
    logic [2:0] err_count, err_count2;
    logic [3:0] gate, gate2;

    int checks = 0;
    int errors = 0;

    gate_truth_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
        .truth(truth), .pass(pass), .err_count(err_count)
    );

    gate_truth_sweeper #(.SETTLE_CYCLES(S2), .EXPECTED(EXP)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .c_in(c_in2),
        .a_out(a_out2), .b_out(b_out2), .busy(busy2), .done(done2),
        .truth(truth2), .pass(pass2), .err_count(err_count2)
    );

    // Gate under test: a lookup table indexed by {A,B}
    assign c_in  = gate[{a_out, b_out}];
    assign c_in2 = gate2[{a_out2, b_out2}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] t;
        bit         p;
        logic [2:0] e;
        int         lat;
        string      name;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: apply vectors in order, stop early on mismatch if abort is built in
    task automatic model(input logic [3:0] g, output logic [3:0] t, output bit p,
                         output logic [2:0] e, output int lat);
        int mism;
        t    = 4'b0000;
        mism = 0;
        lat  = 4 * (S + 1) + 1;
        for (int i = 0; i < 4; i++) begin
            t[i] = g[i];
            if (g[i] != EXP[i]) begin
                mism++;
`ifdef SWEEP_EARLY_ABORT_EN
                lat = (i + 1) * (S + 1) + 1;
                break;
`endif
            end
        end
        e = 3'(mism);
        p = (mism == 0);
    endtask

    task automatic run_sweep(input logic [3:0] g, input logic [3:0] et, input bit ep,
                             input logic [2:0] ee, input int el, input string tag);
        int n;
        int vec_err;
        int vi;
        bit got;
        gate = g;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        vec_err = 0;
        got = 1'b0;
        while (n <= 60) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            vi = (n - 1) / (S + 1);
            if (busy !== 1'b1 || a_out !== vi[1] || b_out !== vi[0]) vec_err++;
            tick();
            n++;
        end
        check({tag, "_latency"}, got ? n : -1, el);
        check({tag, "_vec_trace_errs"}, vec_err, 0);
        check({tag, "_truth"}, int'(truth), int'(et));
        check({tag, "_pass"}, int'(pass), int'(ep));
        check({tag, "_err_count"}, int'(err_count), int'(ee));
        check({tag, "_done_ab"}, int'({busy, a_out, b_out}), 3'b100);
        tick();
        check({tag, "_after_done"}, int'({done, busy}), 0);
        check({tag, "_hold"}, int'({truth, pass, err_count}), int'({et, ep, ee}));
        tick();
    endtask

    initial begin
        logic [3:0] mt;
        bit         mp;
        logic [2:0] me;
        int         ml;
        int         dcount, first_done, last_done, bad_gap, n;
        bit         saw_done;

`ifdef SWEEP_EARLY_ABORT_EN
        tbl[0] = '{4'b0110, 4'b0110, 1'b1, 3'd0, 13, "xor"};
        tbl[1] = '{4'b1000, 4'b0000, 1'b0, 3'd1,  7, "and"};
        tbl[2] = '{4'b1110, 4'b1110, 1'b0, 3'd1, 13, "or"};
        tbl[3] = '{4'b0111, 4'b0001, 1'b0, 3'd1,  4, "nand"};
        tbl[4] = '{4'b1001, 4'b0001, 1'b0, 3'd1,  4, "xnor"};
        tbl[5] = '{4'b0000, 4'b0000, 1'b0, 3'd1,  7, "zero"};
`else
        tbl[0] = '{4'b0110, 4'b0110, 1'b1, 3'd0, 13, "xor"};
        tbl[1] = '{4'b1000, 4'b1000, 1'b0, 3'd3, 13, "and"};
        tbl[2] = '{4'b1110, 4'b1110, 1'b0, 3'd1, 13, "or"};
        tbl[3] = '{4'b0111, 4'b0111, 1'b0, 3'd1, 13, "nand"};
        tbl[4] = '{4'b1001, 4'b1001, 1'b0, 3'd4, 13, "xnor"};
        tbl[5] = '{4'b0000, 4'b0000, 1'b0, 3'd2, 13, "zero"};
`endif

        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        gate   = 4'b0110;
        gate2  = 4'b0110;
        #1;
        check("reset_outputs", int'({a_out, b_out, busy, done, truth, pass, err_count}), 0);
        check("reset_outputs2", int'({a_out2, b_out2, busy2, done2, truth2, pass2, err_count2}), 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", int'({a_out, b_out, busy, done}), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].g, tbl[i].t, tbl[i].p, tbl[i].e, tbl[i].lat, tbl[i].name);
        end

        for (int r = 0; r < 8; r++) begin
            logic [3:0] g;
            g = 4'($urandom_range(0, 15));
            model(g, mt, mp, me, ml);
            run_sweep(g, mt, mp, me, ml, $sformatf("rand%0d", r));
        end

        // Reset asserted in cycle k+5 of a sweep
        gate = 4'b0110;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("midsweep_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midsweep_reset_outputs", int'({a_out, b_out, busy, done, truth, pass, err_count}), 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("midsweep_no_done", int'(saw_done), 0);
        run_sweep(4'b0110, 4'b0110, 1'b1, 3'd0, 13, "after_reset");

        // Start held high on the SETTLE_CYCLES=1 instance
        @(negedge clk);
        start2 = 1'b1;
        dcount = 0;
        first_done = -1;
        last_done = -1;
        bad_gap = 0;
        for (n = 1; n <= 60; n++) begin
            tick();
            if (done2) begin
                dcount++;
                if (first_done < 0) first_done = n;
                else if (n - last_done != 11) bad_gap++;
                last_done = n;
                if (truth2 != 4'b0110 || pass2 != 1'b1 || err_count2 != 3'd0) bad_gap++;
            end
        end
        start2 = 1'b0;
        check("b2b_first_done", first_done, 9);
        check("b2b_done_count", dcount, 5);
        check("b2b_bad_gaps", bad_gap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_sweeper.md
# gate_truth_sweeper

Self-checking stimulus/capture stage wrapped around a 2-input combinational gate under test (GUT), e.g. the lab XAND/XOR cell. On a start request it drives `a_out`/`b_out` through all four input combinations, waits a settle interval, and samples the gate's output on `c_in`. It builds a 4-bit truth table and compares it against an expected pattern. It sits directly upstream (it feeds A, B) and downstream (it consumes C) of the gate in the lab top level.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1..15; 0 is illegal.
- `EXPECTED`, default 4'b0110: expected truth table. Bit i is the output for {A,B} = i.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: sweep request, sampled in IDLE only.
- `c_in` in 1: output of the GUT.
- `a_out` out 1: GUT input A, registered.
- `b_out` out 1: GUT input B, registered.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-cycle pulse marking the end of a sweep.
- `truth` out 4: captured table, bit i = `c_in` sampled for vector i.
- `pass` out 1: `truth == EXPECTED`. Valid from the `done` cycle until the next start.
- `err_count` out 3: popcount(`truth ^ EXPECTED`), range 0..4. Same validity as `pass`.

## Operation
- States:
  - IDLE: waits for `start`.
  - SETTLE: holds the current vector while the settle counter runs.
  - SAMPLE: captures `c_in` for the current vector.
  - DONE: reports results for one cycle.
- Internal registers: 2-bit vector index `idx`; settle counter `cnt`, 4 bits.
- IDLE → SETTLE when `start`=1. On that transition: `idx`←0, `cnt`←0, `truth`←0, `pass`←0, `err_count`←0.
- SETTLE:
  - `cnt` increments every cycle.
  - When `cnt == SETTLE_CYCLES-1`, go to SAMPLE.
- SAMPLE:
  - `truth[idx]`←`c_in`.
  - If `idx==3`, go to DONE.
  - Otherwise `idx`←`idx+1`, `cnt`←0, and return to SETTLE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `pass` and `err_count` are registered on DONE entry from the final `truth`, including the bit captured in the last SAMPLE.
  - Next state is IDLE unconditionally.
- Vector order is {A,B} = 00, 01, 10, 11, i.e. `a_out`=`idx[1]`, `b_out`=`idx[0]`.
- In IDLE and DONE, `a_out`=`b_out`=0.
- `start` is ignored while `busy`=1. A `start` held high through DONE is not acted on until the cycle after the return to IDLE.
- `truth`, `pass` and `err_count` hold their values in IDLE until the next accepted start.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state IDLE; `idx`=0; `cnt`=0.
  - `a_out`=0, `b_out`=0, `busy`=0, `done`=0.
  - `truth`=0, `pass`=0, `err_count`=0.
- Reset asserted mid-sweep aborts immediately to the values above. No `done` pulse is produced.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE, then 1 in SAMPLE.
- If `start` is sampled high at edge k:
  - `busy` rises and vector 0 is driven in cycle k+1.
  - `c_in` for vector i is sampled at the end of cycle k+(i+1)(SETTLE_CYCLES+1).
  - `done`=1 in cycle k+4(SETTLE_CYCLES+1)+1. With the defaults this is k+13.
- `busy` falls in the cycle after `done`. The earliest re-start is accepted one cycle after that.
- The GUT's combinational path from `a_out`/`b_out` to `c_in` must settle within SETTLE_CYCLES clock periods.

## Configuration
- `SWEEP_EARLY_ABORT_EN`:
  - Defined: in SAMPLE, if the captured `c_in` differs from `EXPECTED[idx]`, the FSM goes straight to DONE regardless of `idx`. Unvisited `truth` bits stay 0. `pass`=0 and `err_count`=1 on that `done`.
  - Not defined: all four vectors are always applied, and `err_count` counts every mismatch.

## Test plan
- Reset: hold `rst_n`=0, then release → all outputs 0, `busy`=0.
- Defaults, GUT = XOR: pulse `start` at edge k → `done` in cycle k+13, `truth`=4'b0110, `pass`=1, `err_count`=0. `a_out`/`b_out` step through 00, 01, 10, 11, each held 3 cycles.
- GUT = AND with `EXPECTED`=4'b0110, macro undefined → `truth`=4'b1000, `pass`=0, `err_count`=3.
- Same AND stimulus with `SWEEP_EARLY_ABORT_EN` defined → abort at vector 1, `done` in cycle k+7, `truth`=4'b0000, `err_count`=1.
- Assert `rst_n`=0 in cycle k+5 of a sweep → outputs return to reset values at once, no `done`. A new `start` after release completes normally.
- Hold `start`=1 continuously with SETTLE_CYCLES=1 → back-to-back sweeps with `done` every 11 cycles. Each `start` during `busy` has no effect.
